collide_sweep_scheduler: RTL and testbench
==========================================

Name: collide_sweep_scheduler

Overview:
- Sequences one full collision sweep of an NX x NY lattice through a single combinational collider instance.
- Reads each cell's 9 packed populations from population memory, registers them into the collider, and buffers the collider result in a small write FIFO.
- Writes each result back to the same address, in address order.
- Sits between the top-level step controller (start/done), population memory, and the collider.

Parameters:
- NX, 16, lattice width in cells.
- NY, 16, lattice height in cells.
- ADDR_W, 8, memory address width; must satisfy 2^ADDR_W >= NX*NY.
- DEPTH, 4, write-FIFO entries and maximum cells in flight (power of 2, >= 2).

Ports:
- clk  in  1  clock.
- rst  in  1  reset, asynchronous, active-high.
- start  in  1  begin a sweep; accepted only in IDLE.
- omega  in  16  relaxation rate 1/tau, Q3.13, latched on accepted start.
- rd_en  out  1  memory read request.
- rd_addr  out  ADDR_W  read address.
- rd_data  in  144  populations; packing order null,n,ne,e,se,s,sw,w,nw from bit 0 upward, 16 bits each.
- rd_valid  in  1  rd_data valid; one pulse per rd_en, in order, with any latency >= 1.
- col_f  out  144  populations to the collider (same packing).
- col_omega  out  16  latched omega to the collider.
- col_f_new  in  144  collider result (same packing).
- wr_en  out  1  write request; equals FIFO not-empty.
- wr_addr  out  ADDR_W  write address.
- wr_data  out  144  FIFO head.
- wr_ready  in  1  memory accepts the write when wr_en && wr_ready.
- busy  out  1  high in RUN and DRAIN.
- done  out  1  one-cycle pulse when the last write is accepted.

Behaviour:
- Reset values:
  - state = IDLE.
  - rd_en, wr_en, busy, done = 0.
  - rd_addr, wr_addr = 0.
  - col_f, col_omega, FIFO storage, all counters = 0.
- States:
  - IDLE: start=1 latches omega, clears counters, goes to RUN.
  - RUN: issues reads. When the read counter reaches NX*NY, goes to DRAIN.
  - DRAIN: no reads. When the write with wr_addr = NX*NY-1 is accepted, done=1 for that cycle and the state goes to IDLE.
  - The done pulse is asserted in the cycle after that acceptance edge.
- start outside IDLE is ignored. omega changes outside IDLE are ignored.
- Read issue rule: rd_en=1 in RUN when in_flight + fifo_count < DEPTH.
  - in_flight = reads issued but not yet pushed to the FIFO.
  - rd_addr increments from 0 by 1 on each rd_en.
- Capture pipeline:
  - The edge where rd_valid=1 loads col_f <= rd_data and sets the stage-valid flag.
  - On the next edge, col_f_new is pushed into the FIFO and in_flight is decremented.
  - Minimum latency from rd_valid to wr_en is 2 cycles.
- FIFO:
  - Show-ahead; wr_data = head.
  - Pop on wr_en && wr_ready; wr_addr increments on each pop.
  - Push and pop in the same cycle keeps fifo_count unchanged.
  - Overflow is impossible by the credit rule. A push when full is a design error; the bench asserts it never happens.
- Simultaneous rd_en and push in the same cycle: in_flight unchanged.
- in_flight + fifo_count never exceeds DEPTH.
- Address counters wrap only via IDLE clear; no modular wrap within a sweep.
- wr_ready=0 holds wr_en, wr_addr and wr_data stable until accepted.
- Reset asserted mid-sweep:
  - All outputs return to reset values immediately (asynchronous).
  - FIFO contents are discarded; no done pulse.
- Sweep of NX*NY = 1: a single read and a single write, then done.

Test Plan:
- Stub collider (col_f_new = col_f + 1 per lane), NX=NY=4, RD_LAT=1, wr_ready=1, start with omega=0x2000:
  - 16 writes, wr_addr 0..15 in order.
  - Each lane equals read value + 1.
  - Exactly one done pulse; busy high from the cycle after start until the done cycle.
- wr_ready held 0 after start:
  - Exactly DEPTH=4 rd_en pulses, then rd_en stays 0.
  - wr_en=1 with wr_addr=0 stable.
  - Releasing wr_ready completes all 16 writes in order.
- Random rd_valid latency 1-5 and random wr_ready, NX=NY=4:
  - Write sequence and data identical to the first scenario.
  - in_flight + fifo_count <= 4 every cycle.
- start pulsed again mid-sweep with omega=0x1000:
  - Ignored; col_omega stays 0x2000; still exactly 16 writes and one done.
- rst asserted after 7 writes:
  - rd_en, wr_en, busy and done are 0 in the same cycle.
  - A new start restarts at rd_addr=0 and wr_addr=0.
- Real collider, omega=0x2000, all cells at rest (f = 0x0e39, 0x038e x4, 0x00e4 x4):
  - Every written lane within ±2 LSB of its input.

Source files
------------

// File: rtl/collide_sweep_scheduler.sv
// Purpose: steps one collision sweep of an NX x NY lattice through a single collider, writing results back in address order.
// Latency: a result reaches the write port 2 cycles after its rd_valid, at the earliest; done follows the last accepted write by 1 cycle.
// Backpressure: wr_ready=0 stalls the FIFO head. Reads stop once in_flight + fifo_count reaches DEPTH, so the FIFO cannot overflow.
//
// Ports:
//   clk, rst                      clock; asynchronous active-high reset
//   start, omega                  sweep request; omega (Q3.13) is latched when start is accepted in IDLE
//   rd_en, rd_addr                read request to population memory
//   rd_data, rd_valid             returned populations, in order, one per rd_en
//   col_f, col_omega, col_f_new   registered collider input and its combinational result
//   wr_en, wr_addr, wr_data       write request (FIFO head)
//   wr_ready                      write accepted when wr_en && wr_ready
//   busy, done                    busy in RUN/DRAIN; done pulses once per sweep
module collide_sweep_scheduler #(
  parameter int NX     = 16,
  parameter int NY     = 16,
  parameter int ADDR_W = 8,
  parameter int DEPTH  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [15:0]       omega,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [143:0]      rd_data,
  input  logic              rd_valid,
  output logic [143:0]      col_f,
  output logic [15:0]       col_omega,
  input  logic [143:0]      col_f_new,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [143:0]      wr_data,
  input  logic              wr_ready,
  output logic              busy,
  output logic              done
);

  localparam int CW = ADDR_W + 1;          // one extra bit so the count can reach NX*NY
  localparam int PW = $clog2(DEPTH);
  localparam int NW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] LAST_C  = CW'(NX * NY - 1);
  localparam logic [CW-1:0] TOTAL_C = CW'(NX * NY);
  localparam logic [NW:0]   DEPTH_C = (NW + 1)'(DEPTH);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  state_t          state_q, state_d;
  logic [15:0]     omega_q, omega_d;
  logic [CW-1:0]   rd_cnt_q, rd_cnt_d;
  logic [CW-1:0]   wr_cnt_q, wr_cnt_d;
  logic [NW-1:0]   in_flight_q, in_flight_d;
  logic [NW-1:0]   fifo_cnt_q, fifo_cnt_d;
  logic            stg_vld_q, stg_vld_d;
  logic [143:0]    col_f_q, col_f_d;
  logic [143:0]    mem_q [DEPTH];
  logic [143:0]    mem_d [DEPTH];
  logic [PW-1:0]   head_q, head_d;
  logic [PW-1:0]   tail_q, tail_d;
  logic            done_q, done_d;

  logic            issue;
  logic            push;
  logic            pop;
  logic [NW:0]     credit_sum;

  always_comb begin
    credit_sum  = {1'b0, in_flight_q} + {1'b0, fifo_cnt_q};
    // Every issued read holds one credit until its result leaves the FIFO.
    issue       = (state_q == RUN) && (rd_cnt_q < TOTAL_C) && (credit_sum < DEPTH_C);
    push        = stg_vld_q;
    pop         = (fifo_cnt_q != '0) && wr_ready;

    state_d     = state_q;
    omega_d     = omega_q;
    rd_cnt_d    = rd_cnt_q;
    wr_cnt_d    = wr_cnt_q;
    in_flight_d = in_flight_q + NW'(issue) - NW'(push);
    fifo_cnt_d  = fifo_cnt_q + NW'(push) - NW'(pop);
    stg_vld_d   = rd_valid && (state_q != IDLE);
    col_f_d     = col_f_q;
    mem_d       = mem_q;
    head_d      = head_q;
    tail_d      = tail_q;
    done_d      = 1'b0;

    if (stg_vld_d) col_f_d = rd_data;
    if (issue) rd_cnt_d = rd_cnt_q + 1'b1;
    if (push) begin
      mem_d[tail_q] = col_f_new;
      tail_d        = tail_q + 1'b1;   // DEPTH is a power of 2, so pointers wrap naturally
    end
    if (pop) begin
      head_d   = head_q + 1'b1;
      wr_cnt_d = wr_cnt_q + 1'b1;
    end

    unique case (state_q)
      IDLE: begin
        if (start) begin
          omega_d  = omega;
          rd_cnt_d = '0;
          wr_cnt_d = '0;
          state_d  = RUN;
        end
      end
      RUN: begin
        if (issue && (rd_cnt_q == LAST_C)) state_d = DRAIN;
      end
      DRAIN: begin
        if (pop && (wr_cnt_q == LAST_C)) begin
          done_d  = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      omega_q     <= '0;
      rd_cnt_q    <= '0;
      wr_cnt_q    <= '0;
      in_flight_q <= '0;
      fifo_cnt_q  <= '0;
      stg_vld_q   <= 1'b0;
      col_f_q     <= '0;
      head_q      <= '0;
      tail_q      <= '0;
      done_q      <= 1'b0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      state_q     <= state_d;
      omega_q     <= omega_d;
      rd_cnt_q    <= rd_cnt_d;
      wr_cnt_q    <= wr_cnt_d;
      in_flight_q <= in_flight_d;
      fifo_cnt_q  <= fifo_cnt_d;
      stg_vld_q   <= stg_vld_d;
      col_f_q     <= col_f_d;
      head_q      <= head_d;
      tail_q      <= tail_d;
      done_q      <= done_d;
      mem_q       <= mem_d;
    end
  end

  assign rd_en     = issue;
  assign rd_addr   = rd_cnt_q[ADDR_W-1:0];
  assign col_f     = col_f_q;
  assign col_omega = omega_q;
  assign wr_en     = (fifo_cnt_q != '0);
  assign wr_addr   = wr_cnt_q[ADDR_W-1:0];
  assign wr_data   = mem_q[head_q];
  assign busy      = (state_q != IDLE);
  assign done      = done_q;

endmodule

// File: tb/tb_collide_sweep_scheduler.sv
module tb_collide_sweep_scheduler;
  localparam int NX = 4, NY = 4, AW = 8, DEPTH = 4, N = NX * NY;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst;
  logic          start;
  logic [15:0]   omega;
  logic          rd_en, rd_valid, wr_en, wr_ready, busy, done;
  logic [AW-1:0] rd_addr, wr_addr;
  logic [143:0]  rd_data, col_f, col_f_new, wr_data;
  logic [15:0]   col_omega;
  bit            real_col;

  // Single-cell lattice instance
  logic          start1, rd_en1, rd_valid1, wr_en1, busy1, done1;
  logic [15:0]   omega1, col_omega1;
  logic [AW-1:0] rd_addr1, wr_addr1;
  logic [143:0]  rd_data1, col_f1, col_f_new1, wr_data1;

  collide_sweep_scheduler #(.NX(NX), .NY(NY), .ADDR_W(AW), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .start(start), .omega(omega),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data), .rd_valid(rd_valid),
    .col_f(col_f), .col_omega(col_omega), .col_f_new(col_f_new),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_ready(wr_ready),
    .busy(busy), .done(done));

  collide_sweep_scheduler #(.NX(1), .NY(1), .ADDR_W(AW), .DEPTH(DEPTH)) dut1 (
    .clk(clk), .rst(rst), .start(start1), .omega(omega1),
    .rd_en(rd_en1), .rd_addr(rd_addr1), .rd_data(rd_data1), .rd_valid(rd_valid1),
    .col_f(col_f1), .col_omega(col_omega1), .col_f_new(col_f_new1),
    .wr_en(wr_en1), .wr_addr(wr_addr1), .wr_data(wr_data1), .wr_ready(1'b1),
    .busy(busy1), .done(done1));

  function automatic logic [143:0] add1(input logic [143:0] f);
    logic [143:0] r;
    for (int i = 0; i < 9; i++) r[16*i +: 16] = f[16*i +: 16] + 16'd1;
    return r;
  endfunction

  // Behavioural D2Q9 BGK collider in real arithmetic, Q3.13 in and out.
  function automatic logic [143:0] bgk(input logic [143:0] f, input logic [15:0] om);
    real fr [9];
    int  cx [9];
    int  cy [9];
    real rho, ux, uy, cu, usq, w, feq, o, r;
    int  ri;
    logic [143:0] res;
    cx = '{0, 0, 1, 1, 1, 0, -1, -1, -1};
    cy = '{0, 1, 1, 0, -1, -1, -1, 0, 1};
    o = real'(om) / 8192.0;
    rho = 0.0; ux = 0.0; uy = 0.0;
    for (int i = 0; i < 9; i++) begin
      fr[i] = real'(f[16*i +: 16]) / 8192.0;
      rho += fr[i];
      ux  += cx[i] * fr[i];
      uy  += cy[i] * fr[i];
    end
    if (rho > 0.0) begin ux = ux / rho; uy = uy / rho; end
    usq = ux * ux + uy * uy;
    for (int i = 0; i < 9; i++) begin
      w   = (i == 0) ? 4.0 / 9.0 : ((i % 2) == 1 ? 1.0 / 9.0 : 1.0 / 36.0);
      cu  = cx[i] * ux + cy[i] * uy;
      feq = w * rho * (1.0 + 3.0 * cu + 4.5 * cu * cu - 1.5 * usq);
      r   = fr[i] - o * (fr[i] - feq);
      ri  = $rtoi(r * 8192.0 + 0.5);
      if (ri < 0) ri = 0;
      if (ri > 65535) ri = 65535;
      res[16*i +: 16] = 16'(ri);
    end
    return res;
  endfunction

  always_comb col_f_new  = real_col ? bgk(col_f, col_omega) : add1(col_f);
  always_comb col_f_new1 = add1(col_f1);

  // ---------------- bench state / reference model ----------------
  int tests = 0, fails = 0;
  logic [143:0] pmem [N];
  typedef struct { int addr; int due; } req_t;
  req_t pq[$];
  int  cyc = 0, last_due, lat_min, lat_max, rdy_pct;
  bit  start_req;
  logic [15:0] omega_req;
  int  exp_rd, exp_wr, issued, accepted, dones, busy_low, last_acc_cyc, done_cyc;
  bit  in_sweep;

  task automatic chk(input string nm, input logic [143:0] act, input logic [143:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  task automatic model_clear();
    pq.delete();
    last_due = 0; exp_rd = 0; exp_wr = 0; issued = 0; accepted = 0;
    dones = 0; busy_low = 0; in_sweep = 0; last_acc_cyc = -10; done_cyc = -1;
  endtask

  task automatic tick();
    int d;
    bit ok;
    @(negedge clk);
    cyc++;
    start     = start_req;
    omega     = omega_req;
    start_req = 1'b0;
    if (pq.size() > 0 && pq[0].due <= cyc) begin
      rd_valid = 1'b1;
      rd_data  = pmem[pq[0].addr];
      void'(pq.pop_front());
    end else begin
      rd_valid = 1'b0;
    end
    wr_ready = ($urandom_range(99) < rdy_pct);
    #1;
    // Outstanding reads not yet written == in_flight + fifo_count.
    chk("credit_bound", 144'(issued - accepted <= DEPTH), 144'(1));
    if (rd_en) begin
      chk("rd_addr", 144'(rd_addr), 144'(exp_rd));
      if (exp_rd < N) begin
        d = cyc + $urandom_range(lat_max, lat_min);
        if (d <= last_due) d = last_due + 1;
        pq.push_back('{exp_rd, d});
        last_due = d;
      end
      exp_rd++; issued++;
    end
    if (wr_en && wr_ready) begin
      chk("wr_addr", 144'(wr_addr), 144'(exp_wr));
      if (exp_wr < N) begin
        if (real_col) begin
          ok = 1'b1;
          for (int i = 0; i < 9; i++) begin
            d = int'(wr_data[16*i +: 16]) - int'(pmem[exp_wr][16*i +: 16]);
            if (d > 2 || d < -2) ok = 1'b0;
          end
          chk("wr_lane_tol", 144'(ok), 144'(1));
        end else begin
          chk("wr_data", wr_data, add1(pmem[exp_wr]));
        end
      end
      exp_wr++; accepted++;
      if (exp_wr == N) last_acc_cyc = cyc;
    end
    if (done) begin dones++; done_cyc = cyc; end
    if (in_sweep && !done && !busy) busy_low++;
    if (done) in_sweep = 1'b0;
  endtask

  task automatic fill_random();
    for (int a = 0; a < N; a++)
      for (int i = 0; i < 9; i++) pmem[a][16*i +: 16] = 16'($urandom);
  endtask

  task automatic fill_rest();
    for (int a = 0; a < N; a++)
      for (int i = 0; i < 9; i++)
        pmem[a][16*i +: 16] = (i == 0) ? 16'h0e39 : ((i % 2) == 1 ? 16'h038e : 16'h00e4);
  endtask

  task automatic begin_sweep(input logic [15:0] om);
    model_clear();
    start_req = 1'b1; omega_req = om;
    tick();
    in_sweep = 1'b1;
  endtask

  typedef struct {
    int lmin; int lmax; int rdy; logic [15:0] om; bit restart; bit realc; logic [15:0] exp_om;
  } vec_t;
  vec_t vt [5];

  task automatic run_vec(input vec_t v);
    bit restarted = 1'b0;
    lat_min = v.lmin; lat_max = v.lmax; rdy_pct = v.rdy; real_col = v.realc;
    if (v.realc) fill_rest(); else fill_random();
    begin_sweep(v.om);
    for (int n = 0; n < 2000 && dones == 0; n++) begin
      omega_req = 16'($urandom);
      if (v.restart && !restarted && accepted == 5) begin
        start_req = 1'b1; omega_req = 16'h1000; restarted = 1'b1;
      end
      tick();
    end
    chk("sweep_done_seen", 144'(dones), 144'(1));
    for (int n = 0; n < 8; n++) tick();
    chk("writes", 144'(accepted), 144'(N));
    chk("reads", 144'(issued), 144'(N));
    chk("done_count", 144'(dones), 144'(1));
    chk("done_timing", 144'(done_cyc), 144'(last_acc_cyc + 1));
    chk("busy_gap", 144'(busy_low), 144'(0));
    chk("busy_after", 144'(busy), 144'(0));
    chk("col_omega", 144'(col_omega), 144'(v.exp_om));
  endtask

  logic [143:0] held;
  int  rd1, wr1, dn1;
  bit  rd1_prev;

  initial begin
    vt[0] = '{1, 1, 100, 16'h2000, 1'b0, 1'b0, 16'h2000};
    vt[1] = '{1, 5,  60, 16'h2000, 1'b0, 1'b0, 16'h2000};
    vt[2] = '{1, 5, 100, 16'h2000, 1'b1, 1'b0, 16'h2000};
    vt[3] = '{2, 3,  30, 16'h3000, 1'b0, 1'b0, 16'h3000};
    vt[4] = '{1, 1, 100, 16'h2000, 1'b0, 1'b1, 16'h2000};

    rst = 1'b1; start = 1'b0; omega = '0; rd_valid = 1'b0; rd_data = '0; wr_ready = 1'b0;
    start1 = 1'b0; omega1 = '0; rd_valid1 = 1'b0; rd_data1 = '0;
    start_req = 1'b0; omega_req = '0; lat_min = 1; lat_max = 1; rdy_pct = 100;
    model_clear();
    repeat (2) @(negedge clk);
    #1;
    chk("rst_rd_en", 144'(rd_en), 144'(0));
    chk("rst_wr_en", 144'(wr_en), 144'(0));
    chk("rst_busy", 144'(busy), 144'(0));
    chk("rst_done", 144'(done), 144'(0));
    chk("rst_addrs", 144'({rd_addr, wr_addr}), 144'(0));
    chk("rst_col", {col_f[127:0], col_omega}, 144'(0));
    @(negedge clk);
    rst = 1'b0;

    for (int k = 0; k < 5; k++) run_vec(vt[k]);

    // Write stall: reads stop at DEPTH credits, head holds steady.
    lat_min = 1; lat_max = 1; rdy_pct = 0; real_col = 1'b0;
    fill_random();
    begin_sweep(16'h2000);
    for (int n = 0; n < 30; n++) begin
      tick();
      if (n == 10) held = wr_data;
    end
    chk("stall_reads", 144'(issued), 144'(DEPTH));
    chk("stall_wr_en", 144'(wr_en), 144'(1));
    chk("stall_wr_addr", 144'(wr_addr), 144'(0));
    chk("stall_wr_data_hold", wr_data, held);
    chk("stall_wr_data", wr_data, add1(pmem[0]));
    rdy_pct = 100;
    for (int n = 0; n < 500 && dones == 0; n++) tick();
    for (int n = 0; n < 4; n++) tick();
    chk("stall_writes", 144'(accepted), 144'(N));
    chk("stall_done", 144'(dones), 144'(1));

    // Reset after 7 writes, then a clean restart from address 0.
    lat_min = 1; lat_max = 3; rdy_pct = 100;
    fill_random();
    begin_sweep(16'h2000);
    for (int n = 0; n < 500 && accepted < 7; n++) tick();
    chk("pre_rst_writes", 144'(accepted), 144'(7));
    #2 rst = 1'b1;
    #1;
    chk("mid_rst_rd_en", 144'(rd_en), 144'(0));
    chk("mid_rst_wr_en", 144'(wr_en), 144'(0));
    chk("mid_rst_busy", 144'(busy), 144'(0));
    chk("mid_rst_done", 144'(done), 144'(0));
    chk("mid_rst_addrs", 144'({rd_addr, wr_addr}), 144'(0));
    model_clear();
    @(negedge clk);
    rst = 1'b0;
    run_vec(vt[0]);

    // Single-cell sweep on the 1x1 instance.
    rd1 = 0; wr1 = 0; dn1 = 0; rd1_prev = 1'b0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      start1    = (c == 0);
      omega1    = (c == 0) ? 16'h2000 : 16'h0777;
      rd_valid1 = rd1_prev;
      rd_data1  = 144'h1234_5678_9abc_def0_1111_2222_3333_4444_5555;
      #1;
      if (rd_en1) begin rd1++; chk("one_rd_addr", 144'(rd_addr1), 144'(0)); end
      rd1_prev = rd_en1;
      if (wr_en1) begin
        wr1++;
        chk("one_wr_addr", 144'(wr_addr1), 144'(0));
        chk("one_wr_data", wr_data1, add1(rd_data1));
      end
      if (done1) dn1++;
    end
    chk("one_reads", 144'(rd1), 144'(1));
    chk("one_writes", 144'(wr1), 144'(1));
    chk("one_done", 144'(dn1), 144'(1));
    chk("one_idle", 144'({busy1, col_omega1}), 144'({1'b0, 16'h2000}));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
